// File: rtl/decode_stage.sv
// Registered RV32I+M/Zicsr decode stage: valid/ready input, one-entry output register,
// load-use interlock, flush and a saturating stall counter.
module decode_stage #(
  parameter int unsigned XLEN        = 32,
  parameter bit          EN_M_EXT    = 1'b1,
  parameter bit          EN_CSR      = 1'b1,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [31:0]            inst_i,
  input  logic [XLEN-1:0]        inst_addr_i,
  output logic [4:0]             reg1_addr_o,
  output logic [4:0]             reg2_addr_o,
  input  logic [XLEN-1:0]        reg1_data_i,
  input  logic [XLEN-1:0]        reg2_data_i,
  output logic [11:0]            csr_rd_addr_o,
  input  logic [XLEN-1:0]        csr_data_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [31:0]            inst_o,
  output logic [XLEN-1:0]        inst_addr_o,
  output logic [XLEN-1:0]        op1_o,
  output logic [XLEN-1:0]        op2_o,
  output logic [XLEN-1:0]        op1_jump_o,
  output logic [XLEN-1:0]        op2_jump_o,
  output logic [XLEN-1:0]        reg2_data_o,
  output logic                   reg_wr_en_o,
  output logic [4:0]             reg_wr_addr_o,
  output logic                   csr_wr_en_o,
  output logic [11:0]            csr_wr_addr_o,
  output logic [XLEN-1:0]        csr_rd_data_o,
  output logic                   illegal_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
);

  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcSystem = 7'b1110011;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd, rs1, rs2;

  assign opcode = inst_i[6:0];
  assign funct3 = inst_i[14:12];
  assign funct7 = inst_i[31:25];
  assign rd     = inst_i[11:7];
  assign rs1    = inst_i[19:15];
  assign rs2    = inst_i[24:20];

  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_u;

  assign imm_i = XLEN'($signed(inst_i[31:20]));
  assign imm_s = XLEN'($signed({inst_i[31:25], inst_i[11:7]}));
  assign imm_b = XLEN'($signed({inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0}));
  assign imm_j = XLEN'($signed({inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0}));
  assign imm_u = XLEN'($signed({inst_i[31:12], 12'b0}));

  logic            legal, use_rs1, use_rs2, wr_rd, is_csr;
  logic [XLEN-1:0] op1_d, op2_d, op1_jump_d, op2_jump_d, reg2_data_d, csr_rd_data_d;
  logic            reg_wr_en_d, csr_wr_en_d;
  logic [4:0]      reg_wr_addr_d;
  logic [11:0]     csr_wr_addr_d;

  always_comb begin
    legal         = 1'b0;
    use_rs1       = 1'b0;
    use_rs2       = 1'b0;
    wr_rd         = 1'b0;
    is_csr        = 1'b0;
    op1_d         = '0;
    op2_d         = '0;
    op1_jump_d    = '0;
    op2_jump_d    = '0;
    reg2_data_d   = '0;
    csr_rd_data_d = '0;
    case (opcode)
      OpcOpImm: begin
        use_rs1 = 1'b1;
        wr_rd   = 1'b1;
        op1_d   = reg1_data_i;
        op2_d   = imm_i;
        case (funct3)
          3'b001:  legal = (funct7 == 7'b0000000);
          3'b101:  legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
          default: legal = 1'b1;
        endcase
      end
      OpcOp: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        wr_rd   = 1'b1;
        op1_d   = reg1_data_i;
        op2_d   = reg2_data_i;
        legal   = (funct7 == 7'b0000000)
               || ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)))
               || ((funct7 == 7'b0000001) && EN_M_EXT);
      end
      OpcLoad: begin
        use_rs1 = 1'b1;
        wr_rd   = 1'b1;
        op1_d   = reg1_data_i;
        op2_d   = imm_i;
        legal   = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
      end
      OpcStore: begin
        use_rs1     = 1'b1;
        use_rs2     = 1'b1;
        op1_d       = reg1_data_i;
        op2_d       = imm_s;
        reg2_data_d = reg2_data_i;
        legal       = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
      end
      OpcBranch: begin
        use_rs1    = 1'b1;
        use_rs2    = 1'b1;
        op1_d      = reg1_data_i;
        op2_d      = reg2_data_i;
        op1_jump_d = inst_addr_i;
        op2_jump_d = imm_b;
        legal      = (funct3 != 3'b010) && (funct3 != 3'b011);
      end
      OpcJal: begin
        wr_rd      = 1'b1;
        op1_d      = inst_addr_i;
        op2_d      = XLEN'(32'd4);
        op1_jump_d = inst_addr_i;
        op2_jump_d = imm_j;
        legal      = 1'b1;
      end
      OpcJalr: begin
        use_rs1    = 1'b1;
        wr_rd      = 1'b1;
        op1_d      = inst_addr_i;
        op2_d      = XLEN'(32'd4);
        op1_jump_d = reg1_data_i;
        op2_jump_d = imm_i;
        legal      = (funct3 == 3'b000);
      end
      OpcLui: begin
        wr_rd = 1'b1;
        op2_d = imm_u;
        legal = 1'b1;
      end
      OpcAuipc: begin
        wr_rd = 1'b1;
        op1_d = inst_addr_i;
        op2_d = imm_u;
        legal = 1'b1;
      end
      OpcSystem: begin
        is_csr        = EN_CSR && (funct3 != 3'b000) && (funct3 != 3'b100);
        legal         = is_csr;
        wr_rd         = 1'b1;
        // funct3[2] selects the immediate (zimm) form, which reads no register
        use_rs1       = !funct3[2];
        op1_d         = funct3[2] ? XLEN'(rs1) : reg1_data_i;
        op2_d         = csr_data_i;
        csr_rd_data_d = csr_data_i;
      end
      default: ;
    endcase
    if (!legal) begin
      use_rs1       = 1'b0;
      use_rs2       = 1'b0;
      wr_rd         = 1'b0;
      is_csr        = 1'b0;
      op1_d         = '0;
      op2_d         = '0;
      op1_jump_d    = '0;
      op2_jump_d    = '0;
      reg2_data_d   = '0;
      csr_rd_data_d = '0;
    end
  end

  assign reg_wr_en_d   = wr_rd && (rd != 5'd0);
  assign reg_wr_addr_d = reg_wr_en_d ? rd : 5'd0;
  assign csr_wr_en_d   = is_csr;
  assign csr_wr_addr_d = is_csr ? inst_i[31:20] : 12'd0;

  assign reg1_addr_o   = use_rs1 ? rs1 : 5'd0;
  assign reg2_addr_o   = use_rs2 ? rs2 : 5'd0;
  assign csr_rd_addr_o = csr_wr_addr_d;

  logic                   out_valid_q, out_valid_d;
  logic [31:0]            inst_q;
  logic [XLEN-1:0]        inst_addr_q, op1_q, op2_q, op1_jump_q, op2_jump_q;
  logic [XLEN-1:0]        reg2_data_q, csr_rd_data_q;
  logic                   reg_wr_en_q, csr_wr_en_q, illegal_q;
  logic [4:0]             reg_wr_addr_q;
  logic [11:0]            csr_wr_addr_q;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic                   hazard, accept;

  // Unused source addresses decode to 0 and a held write never targets x0, so 0 never matches.
  assign hazard = out_valid_q && (inst_q[6:0] == OpcLoad) && reg_wr_en_q
               && ((reg1_addr_o == reg_wr_addr_q) || (reg2_addr_o == reg_wr_addr_q));

  assign in_ready_o = (!out_valid_q || out_ready_i) && !hazard && !flush_i;
  assign accept     = in_valid_i && in_ready_o;

  always_comb begin
    out_valid_d = out_valid_q;
    if (flush_i) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
    stall_cnt_d = stall_cnt_q;
    if (in_valid_i && hazard && !flush_i && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_q        <= '0;
      inst_addr_q   <= '0;
      op1_q         <= '0;
      op2_q         <= '0;
      op1_jump_q    <= '0;
      op2_jump_q    <= '0;
      reg2_data_q   <= '0;
      reg_wr_en_q   <= 1'b0;
      reg_wr_addr_q <= '0;
      csr_wr_en_q   <= 1'b0;
      csr_wr_addr_q <= '0;
      csr_rd_data_q <= '0;
      illegal_q     <= 1'b0;
    end else if (accept) begin
      inst_q        <= inst_i;
      inst_addr_q   <= inst_addr_i;
      op1_q         <= op1_d;
      op2_q         <= op2_d;
      op1_jump_q    <= op1_jump_d;
      op2_jump_q    <= op2_jump_d;
      reg2_data_q   <= reg2_data_d;
      reg_wr_en_q   <= reg_wr_en_d;
      reg_wr_addr_q <= reg_wr_addr_d;
      csr_wr_en_q   <= csr_wr_en_d;
      csr_wr_addr_q <= csr_wr_addr_d;
      csr_rd_data_q <= csr_rd_data_d;
      illegal_q     <= !legal;
    end
  end

  assign out_valid_o   = out_valid_q;
  assign inst_o        = inst_q;
  assign inst_addr_o   = inst_addr_q;
  assign op1_o         = op1_q;
  assign op2_o         = op2_q;
  assign op1_jump_o    = op1_jump_q;
  assign op2_jump_o    = op2_jump_q;
  assign reg2_data_o   = reg2_data_q;
  assign reg_wr_en_o   = reg_wr_en_q;
  assign reg_wr_addr_o = reg_wr_addr_q;
  assign csr_wr_en_o   = csr_wr_en_q;
  assign csr_wr_addr_o = csr_wr_addr_q;
  assign csr_rd_data_o = csr_rd_data_q;
  assign illegal_o     = illegal_q;
  assign stall_cnt_o   = stall_cnt_q;

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, handshaked RV32 instruction decode stage; successor to the combinational decoder.
- Sits between the IF/ID register and execute. It accepts one instruction per cycle over valid/ready, reads the register file and CSR file combinationally, and holds one decoded instruction in an output register.
- Adds full RV32I+M/Zicsr operand selection, illegal-instruction flagging, flush, load-use interlock and a stall counter.

Parameters:
XLEN, 32, datapath / PC / operand width; immediates sign-extended to XLEN
EN_M_EXT, 1, 1 = accept funct7=0000001 OP instructions; 0 = flag them illegal
EN_CSR, 1, 1 = decode Zicsr; 0 = SYSTEM opcode illegal
STALL_CNT_W, 16, width of saturating load-use stall counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush_i  in  1  discard held and incoming instruction
in_valid_i  in  1  inst_i/inst_addr_i valid
in_ready_o  out  1  stage accepts this cycle
inst_i  in  32  instruction
inst_addr_i  in  XLEN  instruction PC
reg1_addr_o  out  5  rs1 read address (comb, from inst_i; 0 if unused)
reg2_addr_o  out  5  rs2 read address (comb, from inst_i; 0 if unused)
reg1_data_i  in  XLEN  rs1 data
reg2_data_i  in  XLEN  rs2 data
csr_rd_addr_o  out  12  CSR read address (comb; 0 if not CSR)
csr_data_i  in  XLEN  CSR read data
out_valid_o  out  1  decoded instruction held
out_ready_i  in  1  execute consumes this cycle
inst_o  out  32  held instruction
inst_addr_o  out  XLEN  held PC
op1_o, op2_o  out  XLEN  ALU operands
op1_jump_o, op2_jump_o  out  XLEN  jump/branch target addends
reg2_data_o  out  XLEN  store data (rs2)
reg_wr_en_o  out  1  writes rd
reg_wr_addr_o  out  5  rd
csr_wr_en_o  out  1  writes CSR
csr_wr_addr_o  out  12  CSR address
csr_rd_data_o  out  XLEN  sampled CSR value
illegal_o  out  1  held instruction illegal
stall_cnt_o  out  STALL_CNT_W  load-use stall cycles, saturating

Behaviour:
- Reset (async, rst_n=0): all registered outputs 0; out_valid_o=0; stall_cnt_o=0.
- Hazard (comb): out_valid_o & held opcode LOAD & reg_wr_en_o & reg_wr_addr_o matches a used rs1/rs2 of inst_i.
- in_ready_o = (!out_valid_o | out_ready_i) & !hazard & !flush_i.
- Accept: in_valid_i & in_ready_o. Latency is 1 cycle; all fields, including sampled reg/CSR data, are registered on the accepting edge.
- If out_ready_i is high with no accept, out_valid_o clears. While hazard holds the load and execute consumes it, out_valid_o drops for one cycle (bubble); the dependent is accepted on the next cycle.
- flush_i has priority: out_valid_o=0 at the next edge, nothing accepted. Flush during a hazard still clears the counter condition.
- stall_cnt_o increments on each cycle with in_valid_i & hazard & !flush_i, and saturates at all-ones.
- Operand decode, by opcode:
  - OP-IMM 0010011: op1=rs1, op2=sextI. SLLI needs funct7=0; SRLI/SRAI need funct7 0/0100000.
  - OP 0110011: op1=rs1, op2=rs2. funct7=0 is legal; 0100000 is legal only with funct3 000/101; 0000001 is legal only if EN_M_EXT.
  - LOAD 0000011: funct3 000/001/010/100/101; op1=rs1, op2=sextI.
  - STORE 0100011: funct3 000/001/010; op1=rs1, op2=sextS, reg2_data_o=rs2, reg_wr_en_o=0.
  - BRANCH 1100011: funct3 not 010/011; op1=rs1, op2=rs2, jump=PC+sextB, no write.
  - JAL 1101111: op1=PC, op2=4, jump=PC+sextJ.
  - JALR 1100111 (funct3 000): op1=PC, op2=4, jump=rs1+sextI.
  - LUI 0110111: op1=0, op2={imm20,12'b0}.
  - AUIPC 0010111: op1=PC, op2={imm20,12'b0}.
  - SYSTEM 1110011, funct3 001/010/011/101/110/111 with EN_CSR: csr_wr_en_o=1, csr_wr_addr_o=inst[31:20], op1=rs1 (funct3[2]=0) or zext zimm inst[19:15] (funct3[2]=1), op2=csr_data_i, csr_rd_data_o=csr_data_i.
- Any other encoding: illegal_o=1; reg_wr_en_o=0, csr_wr_en_o=0, operands 0; still passed downstream with out_valid_o=1.
- reg_wr_en_o is forced to 0 when rd=0. Unused jump/CSR fields are 0.

Test Plan:
- Reset mid-stream: rst_n low while out_valid_o=1 -> all outputs 0 immediately; after release, first ADDI x1,x2,-1 with reg1_data=5 gives op1=5, op2=0xFFFFFFFF and out_valid_o=1 one cycle later.
- Backpressure: out_ready_i=0 with two instructions presented -> in_ready_o=0, first held stable; out_ready_i=1 -> second accepted the same edge, no loss or duplication.
- Load-use: LW x5,0(x1) then ADD x6,x5,x7 with out_ready_i=1 -> one bubble cycle, stall_cnt_o=1, ADD output on the following cycle. ADD x6,x0,x7 after LW x0 -> no stall.
- Flush: flush_i with a valid held instruction and in_valid_i=1 -> out_valid_o=0 next cycle, input not accepted.
- Decode coverage: JAL x1,+8 at PC 0x100 -> op1=0x100, op2=4, jump sum 0x108. CSRRWI x3,mstatus,7 -> op1=7, csr_wr_addr_o=0x300. MUL with EN_M_EXT=0 -> illegal_o=1, reg_wr_en_o=0.
- Stall saturation: hazard held 2^STALL_CNT_W+3 cycles -> stall_cnt_o stays all-ones.
